// File: rtl/i2s_tx_mclk.sv
// i2s_tx_mclk: I2S transmitter clocked from a recovered audio MCLK.
// The asynchronous MCLK pin is synchronised into clk_i and its rising edges
// pace SCK and WS. 16-bit stereo samples from a valid/accept stream are
// serialised MSB first. A one-entry holding register decouples the stream
// from frame timing.
// Optional build macro I2S_TX_HOLD_LAST_EN: on underrun, repeat the last
// transmitted sample instead of sending a silent (all-zero) frame.
module i2s_tx_mclk #(
  parameter int MCLK_DIV    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mclk_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        i2s_sck_o,
  output logic        i2s_ws_o,
  output logic        i2s_sd_o,
  output logic        underrun_o
);

  localparam int CNT_W = $clog2(MCLK_DIV);
  localparam logic [CNT_W-1:0] CNT_SCK_RISE = CNT_W'(MCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_SCK_FALL = CNT_W'(MCLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mclk_prev_q;
  logic                   mclk_rise;
  logic [CNT_W-1:0]       mclk_cnt_q;
  logic                   sck_q;
  logic                   sck_fall;
  logic [5:0]             bit_cnt_q;
  logic [5:0]             bit_next;
  logic [5:0]             ws_idx;
  logic [3:0]             slot_idx;
  logic                   frame_start;
  logic                   sd_next;
  logic                   ws_q;
  logic                   sd_q;
  logic                   underrun_q;
  logic [31:0]            frame_q;
  logic                   hold_valid_q;
  logic [31:0]            hold_data_q;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [31:0]            last_q;
`endif

  // Synchronise MCLK and keep one extra sample for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      mclk_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], mclk_i};
      mclk_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign mclk_rise = sync_q[SYNC_STAGES-1] & ~mclk_prev_q;
  assign sck_fall  = mclk_rise & (mclk_cnt_q == CNT_SCK_FALL);

  // Count MCLK rising edges and toggle SCK at the half and full period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mclk_cnt_q <= '0;
      sck_q      <= 1'b0;
    end else if (mclk_rise) begin
      mclk_cnt_q <= (mclk_cnt_q == CNT_SCK_FALL) ? '0 : mclk_cnt_q + 1'b1;
      if (mclk_cnt_q == CNT_SCK_RISE) sck_q <= 1'b1;
      if (mclk_cnt_q == CNT_SCK_FALL) sck_q <= 1'b0;
    end
  end

  assign bit_next    = bit_cnt_q + 6'd1;
  assign ws_idx      = bit_next + 6'd1;
  assign frame_start = sck_fall & (bit_next == 6'd0);
  // Both slots map bit b to sample bit (16-b) mod 16, i.e. -b mod 16.
  assign slot_idx    = 4'd0 - bit_next[3:0];

  // Pick the serial bit for the slot position that starts at this SCK fall.
  always_comb begin
    sd_next = 1'b0;
    if (bit_next >= 6'd1 && bit_next <= 6'd16)
      sd_next = frame_q[{1'b0, slot_idx}];
    else if (bit_next >= 6'd33 && bit_next <= 6'd48)
      sd_next = frame_q[{1'b1, slot_idx}];
  end

  // Advance the bit position on SCK fall, drive WS/SD and load frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q  <= 6'd63;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (sck_fall) begin
        bit_cnt_q <= bit_next;
        ws_q      <= ws_idx[5];
        sd_q      <= sd_next;
        if (frame_start) begin
          if (hold_valid_q) begin
            frame_q <= hold_data_q;
          end else begin
`ifdef I2S_TX_HOLD_LAST_EN
            frame_q <= last_q;
`else
            frame_q <= '0;
`endif
            underrun_q <= 1'b1;
          end
        end
      end
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  // Remember the last sample actually handed to the serialiser.
  always_ff @(posedge clk_i) begin
    if (rst_i)                           last_q <= '0;
    else if (frame_start && hold_valid_q) last_q <= hold_data_q;
  end
`endif

  // One-entry holding register; a frame start empties it, a new load wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      if (frame_start && hold_valid_q) hold_valid_q <= 1'b0;
      if (inport_valid_i && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= inport_data_i;
      end
    end
  end

  assign inport_accept_o = ~hold_valid_q;
  assign i2s_sck_o       = sck_q;
  assign i2s_ws_o        = ws_q;
  assign i2s_sd_o        = sd_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_i2s_tx_mclk.sv
// Testbench for i2s_tx_mclk: randomised samples, scoreboard of accepted
// samples and a frame-level model of the I2S bit stream.
module tb_i2s_tx_mclk;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mclk_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [31:0] inport_data_i = '0;
  logic        inport_accept_o;
  logic        i2s_sck_o;
  logic        i2s_ws_o;
  logic        i2s_sd_o;
  logic        underrun_o;

  i2s_tx_mclk #(.MCLK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mclk_i          (mclk_i),
    .inport_valid_i  (inport_valid_i),
    .inport_data_i   (inport_data_i),
    .inport_accept_o (inport_accept_o),
    .i2s_sck_o       (i2s_sck_o),
    .i2s_ws_o        (i2s_ws_o),
    .i2s_sd_o        (i2s_sd_o),
    .underrun_o      (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  logic mclk_run = 1'b0;
  initial forever begin
    #40;
    if (mclk_run) mclk_i = ~mclk_i;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Scoreboard: accepted samples and the clk_i cycle they were taken in.
  logic [31:0] q_data[$];
  int          q_cyc[$];

  int          m_b = 63;
  logic [31:0] m_frame = '0;
  logic [31:0] m_last = '0;
  logic        sck_prev = 1'b0;
  logic        ur_next = 1'b0;
  logic        per_valid = 1'b0;
  int          last_fall = 0;
  int          frames = 0;
  int          ur_seen = 0;
  int          exp_ur_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_sd(input logic [31:0] f, input int b);
    logic [15:0] l;
    logic [15:0] r;
    l = f[15:0];
    r = f[31:16];
    if (b >= 1 && b <= 16)  return ((l >> (16 - b)) & 16'd1) != 16'd0;
    if (b >= 33 && b <= 48) return ((r >> (48 - b)) & 16'd1) != 16'd0;
    return 1'b0;
  endfunction

  // Monitor: on every observed SCK fall, compare WS/SD/underrun with the model.
  always @(negedge clk_i) begin
    logic exp_ur;
    int   tmp;
    if (rst_i) begin
      m_b = 63;
      m_frame = '0;
      m_last = '0;
      sck_prev = 1'b0;
      ur_next = 1'b0;
      per_valid = 1'b0;
      q_data.delete();
      q_cyc.delete();
    end else begin
      if (underrun_o) ur_seen++;
      if (sck_prev && !i2s_sck_o) begin
        m_b = (m_b + 1) % 64;
        if (m_b == 0) begin
          if (q_data.size() > 0 && q_cyc[0] < cyc) begin
            m_frame = q_data.pop_front();
            tmp = q_cyc.pop_front();
            m_last = m_frame;
            exp_ur = 1'b0;
          end else begin
            exp_ur = 1'b1;
            exp_ur_cnt++;
`ifdef I2S_TX_HOLD_LAST_EN
            m_frame = m_last;
`else
            m_frame = '0;
`endif
          end
          check("underrun_at_frame_start", 32'(underrun_o), 32'(exp_ur));
          frames++;
          ur_next = 1'b1;
        end
        check($sformatf("ws_b%0d", m_b), 32'(i2s_ws_o), 32'(((m_b + 1) % 64) >= 32));
        check($sformatf("sd_b%0d", m_b), 32'(i2s_sd_o), 32'(exp_sd(m_frame, m_b)));
        if (per_valid) check("sck_period", 32'(cyc - last_fall), 32'd32);
        last_fall = cyc;
        per_valid = 1'b1;
      end else if (ur_next) begin
        check("underrun_width", 32'(underrun_o), 32'd0);
        ur_next = 1'b0;
      end
      sck_prev = i2s_sck_o;
    end
  end

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 6000) begin
      @(negedge clk_i);
      n++;
    end
    if (frames < target) timeout("wait_frames");
  endtask

  task automatic wait_b(input int b);
    int n = 0;
    while (m_b != b && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    if (m_b != b) timeout("wait_bit");
  endtask

  // Called at a negedge: hold valid until accepted, record it, then drop valid.
  task automatic offer(input logic [31:0] d);
    int n = 0;
    inport_valid_i = 1'b1;
    inport_data_i = d;
    while (!inport_accept_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!inport_accept_o) begin
      timeout("offer");
    end else begin
      q_data.push_back(d);
      q_cyc.push_back(cyc + 1);
      @(negedge clk_i);
    end
    inport_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    logic [4:0]  snap;
    int          f0;
    int          ur0;

    // Reset values.
    repeat (5) @(negedge clk_i);
    check("rst_sck", 32'(i2s_sck_o), 32'd0);
    check("rst_ws", 32'(i2s_ws_o), 32'd0);
    check("rst_sd", 32'(i2s_sd_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    check("rst_accept", 32'(inport_accept_o), 32'd1);
    rst_i = 1'b0;

    // Known sample before the first frame, then an underrun frame.
    @(negedge clk_i);
    offer({16'h8001, 16'h1234});
    check("hold_full_accept", 32'(inport_accept_o), 32'd0);
    mclk_run = 1'b1;
    wait_frames(2);
    @(negedge clk_i);
    check("underruns_after_two_frames", 32'(ur_seen), 32'd1);

    // Continuous random stream for 8 frames: no underrun, none dropped.
    f0 = frames;
    ur0 = ur_seen;
    cur = $urandom;
    while (frames < f0 + 8 && cyc < 60000) begin
      inport_valid_i = 1'b1;
      inport_data_i = cur;
      if (inport_accept_o) begin
        q_data.push_back(cur);
        q_cyc.push_back(cyc + 1);
        cur = $urandom;
      end
      @(negedge clk_i);
    end
    inport_valid_i = 1'b0;
    if (frames < f0 + 8) timeout("stream_frames");
    check("stream_underruns", 32'(ur_seen - ur0), 32'd0);

    // Random per-frame offers at random offsets, some frames starved.
    for (int f = 0; f < 6; f++) begin
      f0 = frames;
      repeat ($urandom_range(1500)) @(negedge clk_i);
      if (f == 1 || (f != 0 && $urandom_range(1) == 1)) offer($urandom);
      wait_frames(f0 + 1);
    end

    // Stop MCLK mid-frame: everything must freeze, then resume in place.
    wait_b(40);
    mclk_run = 1'b0;
    repeat (10) @(negedge clk_i);
    snap = {i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_o, inport_accept_o};
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      check("frozen_outputs", 32'({i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_o, inport_accept_o}), 32'(snap));
    end
    mclk_run = 1'b1;
    per_valid = 1'b0;
    f0 = frames;
    offer($urandom);
    wait_frames(f0 + 1);

    // Reset at b==20 with a held sample; the sample must be discarded.
    offer($urandom);
    wait_b(20);
    check("hold_full_before_reset", 32'(inport_accept_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_sck", 32'(i2s_sck_o), 32'd0);
    check("midrst_ws", 32'(i2s_ws_o), 32'd0);
    check("midrst_sd", 32'(i2s_sd_o), 32'd0);
    check("midrst_underrun", 32'(underrun_o), 32'd0);
    check("midrst_accept", 32'(inport_accept_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    ur0 = ur_seen;
    f0 = frames;
    wait_frames(f0 + 1);
    @(negedge clk_i);
    check("underrun_after_reset", 32'(ur_seen - ur0), 32'd1);
    f0 = frames;
    offer($urandom);
    wait_frames(f0 + 1);
    wait_b(63);

    check("total_underruns", 32'(ur_seen), 32'(exp_ur_cnt));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
